conv_output_drain: RTL and testbench

- Downstream of the convolution controller/datapath. Captures each finished output pixel (accumulator value plus x/y/ch coordinates) on the single-cycle output_valid strobe.
- Buffers results in a small FIFO and streams them to the host over a valid/ready handshake, because the controller cannot stall on output.
- Counts drained results, flags lost data, and signals job completion.

---
 rtl/conv_drain_pkg.sv | 30 +++
 rtl/conv_output_drain_result_fifo.sv | 44 ++++
 rtl/conv_output_drain.sv | 132 +++++++++++++
 tb/tb_conv_output_drain.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_drain_pkg.sv
// Shared types for the convolution output drain: buffered result entry,
// drain FSM states and the job-size helper.
package conv_drain_pkg;

    localparam int RESULT_ACC_W = 32;

    typedef struct packed {
        logic [RESULT_ACC_W-1:0] data;
        logic [31:0]             x;
        logic [31:0]             y;
        logic [31:0]             ch;
    } result_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_t;

    // Number of results in one job, truncated to the 32-bit counter width.
    function automatic logic [31:0] total_results(input int unsigned w,
                                                  input int unsigned h,
                                                  input int unsigned ch);
        logic [63:0] prod;
        prod = 64'(w) * 64'(h) * 64'(ch);
        return prod[31:0];
    endfunction

endpackage

// File: rtl/conv_output_drain_result_fifo.sv
// Synchronous FIFO of result_t entries; pointers carry an extra MSB so that
// full and empty can be told apart when the index bits match.
module result_fifo
    import conv_drain_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic    clk,
    input  logic    arst_n_in,
    input  logic    push,
    input  logic    pop,
    input  result_t entry,
    output logic    full,
    output logic    empty,
    output result_t head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    result_t     mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is data only; occupancy is defined entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= entry;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/conv_output_drain.sv
// Captures finished convolution results, buffers them and streams them to the
// host over valid/ready. Optional ReLU on stored data: CONV_OUTPUT_RELU_EN.
module conv_output_drain
    import conv_drain_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int ACC_WIDTH          = 32,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [ACC_WIDTH-1:0] in_data,
    input  logic [31:0]          in_x,
    input  logic [31:0]          in_y,
    input  logic [31:0]          in_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [31:0]          out_x,
    output logic [31:0]          out_y,
    output logic [31:0]          out_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [31:0]          drained_count
);

    localparam logic [31:0] TOTAL =
        total_results(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);

    drain_state_t state;
    logic [31:0]  accepted_count;
    logic         push_req;
    logic         fifo_push;
    logic         pop;
    logic         full;
    logic         empty;
    result_t      wr_entry;
    result_t      head;
    logic [ACC_WIDTH-1:0] stored_data;

`ifdef CONV_OUTPUT_RELU_EN
    function automatic logic [ACC_WIDTH-1:0] relu(input logic signed [ACC_WIDTH-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction
    assign stored_data = relu(in_data);
`else
    assign stored_data = in_data;
`endif

    // Once TOTAL results have been accepted, further strobes are ignored.
    assign push_req  = (state == RUN) && in_valid && (accepted_count != TOTAL);
    assign pop       = !empty && out_ready;
    assign fifo_push = push_req && (!full || pop);

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = RESULT_ACC_W'(stored_data);
        wr_entry.x    = in_x;
        wr_entry.y    = in_y;
        wr_entry.ch   = in_ch;
    end

    result_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .push     (fifo_push),
        .pop      (pop),
        .entry    (wr_entry),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            accepted_count <= '0;
            drained_count  <= '0;
        end else begin
            if (pop) drained_count <= drained_count + 32'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= RUN;
                        busy           <= 1'b1;
                        accepted_count <= '0;
                        drained_count  <= '0;
                        overflow       <= 1'b0;
                    end
                end
                RUN: begin
                    if (push_req) begin
                        accepted_count <= accepted_count + 32'd1;
                        if (full && !pop) overflow <= 1'b1;
                    end
                    if (accepted_count == TOTAL) state <= FLUSH;
                end
                FLUSH: begin
                    // An empty FIFO has out_valid low, so no pop can be pending.
                    if (empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload is forced to zero while nothing is presented.
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : ACC_WIDTH'(head.data);
    assign out_x     = empty ? '0 : head.x;
    assign out_y     = empty ? '0 : head.y;
    assign out_ch    = empty ? '0 : head.ch;

endmodule

// File: tb/tb_conv_output_drain.sv
// Bench for conv_output_drain: directed job sequences plus randomized traffic,
// checked every cycle against a queue-based model of the drain.
module tb_conv_output_drain;

    localparam int W     = 2;
    localparam int H     = 2;
    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int TOTAL = W * H * CH;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_FLUSH = 2;
    localparam int P_DONE  = 3;

`ifdef CONV_OUTPUT_RELU_EN
    localparam logic [31:0] EXP_NEG = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_NEG = 32'hFFFF_FFFB;
`endif

    logic        clk;
    logic        arst_n_in;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic [31:0] in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_ch;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] drained_count;

    conv_output_drain #(
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .OUTPUT_NB_CHANNELS(CH),
        .ACC_WIDTH         (32),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk          (clk),
        .arst_n_in    (arst_n_in),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_ch        (in_ch),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_ch       (out_ch),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .drained_count(drained_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Reference model: entries are {data, x, y, ch}.
    logic [127:0] q[$];
    int           ph = P_IDLE;
    int           acc_m = 0;
    int           drn_m = 0;
    bit           ovf_m = 1'b0;
    bit           hold_pending = 1'b0;
    logic [127:0] hold_payload = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] relu_m(input logic [31:0] d);
`ifdef CONV_OUTPUT_RELU_EN
        return ($signed(d) < 0) ? 32'd0 : d;
`else
        return d;
`endif
    endfunction

    task automatic check_outputs(input bit rdy);
        logic [127:0] e;
        e = (q.size() > 0) ? q[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("out_data", out_data, e[127:96]);
        chk("out_x", out_x, e[95:64]);
        chk("out_y", out_y, e[63:32]);
        chk("out_ch", out_ch, e[31:0]);
        chk("busy", 32'(busy), 32'(ph == P_RUN || ph == P_FLUSH));
        chk("done", 32'(done), 32'(ph == P_DONE));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("drained_count", drained_count, 32'(drn_m));
        if (hold_pending) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_payload", out_data ^ out_x ^ out_y ^ out_ch,
                hold_payload[127:96] ^ hold_payload[95:64] ^ hold_payload[63:32] ^ hold_payload[31:0]);
        end
        hold_pending = out_valid && !rdy;
        hold_payload = {out_data, out_x, out_y, out_ch};
        if (done) done_seen++;
    endtask

    task automatic model_edge(input bit rstn, input bit st, input bit iv,
                              input logic [127:0] ent, input bit rdy);
        bit pop_m;
        bit push_m;
        int occ;
        if (!rstn) begin
            q.delete();
            ph = P_IDLE;
            acc_m = 0;
            drn_m = 0;
            ovf_m = 1'b0;
            hold_pending = 1'b0;
            return;
        end
        occ    = q.size();
        pop_m  = (occ > 0) && rdy;
        push_m = 1'b0;
        case (ph)
            P_IDLE: if (st) begin
                ph = P_RUN; acc_m = 0; drn_m = 0; ovf_m = 1'b0;
            end
            P_RUN: begin
                if (acc_m == TOTAL) ph = P_FLUSH;
                else if (iv) begin
                    acc_m++;
                    if (occ == DEPTH && !pop_m) ovf_m = 1'b1;
                    else push_m = 1'b1;
                end
            end
            P_FLUSH: if (occ == 0) ph = P_DONE;
            default: ph = P_IDLE;
        endcase
        if (pop_m) begin
            void'(q.pop_front());
            drn_m++;
        end
        if (push_m) q.push_back({relu_m(ent[127:96]), ent[95:0]});
    endtask

    task automatic cyc(input bit rstn, input bit st, input bit iv, input logic [31:0] d,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] c,
                       input bit rdy);
        arst_n_in = rstn; start = st; in_valid = iv;
        in_data = d; in_x = x; in_y = y; in_ch = c; out_ready = rdy;
        @(negedge clk);
        check_outputs(rdy);
        @(posedge clk);
        model_edge(rstn, st, iv, {d, x, y, c}, rdy);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic push1(input logic [31:0] d, input bit rdy);
        cyc(1'b1, 1'b0, 1'b1, d, $urandom, $urandom, $urandom, rdy);
    endtask

    task automatic begin_job();
        done_seen = 0;
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // Keeps pushing (extra strobes past TOTAL must be ignored) until the job ends.
    task automatic finish_job(input bit rnd);
        int n;
        n = 0;
        while (ph != P_IDLE && n < 300) begin
            cyc(1'b1, ($urandom_range(7) == 0), rnd ? 1'($urandom_range(1)) : 1'b1,
                $urandom, $urandom, $urandom, $urandom,
                rnd ? 1'($urandom_range(1)) : 1'b1);
            n++;
        end
        chk("job_timeout", 32'(ph == P_IDLE), 32'd1);
        chk("done_pulses", 32'(done_seen), 32'd1);
    endtask

    initial begin
        arst_n_in = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
        @(posedge clk); #1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);

        // Reset in the middle of a job with three results buffered.
        begin_job();
        repeat (3) push1($urandom, 1'b0);
        chk("t1_buffered", 32'(out_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        done_seen = 0;
        idle(4, 1'b1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_no_done", 32'(done_seen), 32'd0);

        // Full job, host always ready.
        begin_job();
        for (int i = 0; i < TOTAL; i++) push1($urandom, 1'b1);
        finish_job(1'b0);
        chk("t2_drained", drained_count, 32'(TOTAL));

        // Host stalled: six pushes into a four-deep FIFO lose two.
        begin_job();
        repeat (6) push1($urandom, 1'b0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        idle(6, 1'b1);
        chk("t3_drained4", drained_count, 32'd4);
        finish_job(1'b0);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous push and pop keeps everything.
        begin_job();
        repeat (4) push1($urandom, 1'b0);
        push1($urandom, 1'b1);
        chk("t4_no_overflow", 32'(overflow), 32'd0);
        chk("t4_occupancy", 32'(q.size()), 32'd4);
        idle(5, 1'b1);
        chk("t4_drained5", drained_count, 32'd5);
        finish_job(1'b0);

        // Random handshake traffic.
        for (int j = 0; j < 4; j++) begin
            begin_job();
            finish_job(1'b1);
        end

        // ReLU (or pass-through) of a negative value.
        begin_job();
        push1(32'hFFFF_FFFB, 1'b0);
        push1(32'd7, 1'b0);
        chk("t6_first", out_data, EXP_NEG);
        idle(1, 1'b1);
        chk("t6_second", out_data, 32'd7);
        finish_job(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
